// File: rtl/cpu_tick_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cpu_tick_pkg
// Shared encodings for the CPU tick controller.
//   tick_state_e         : operating mode / FSM state, 2-bit, shown on the LEDs
//   DEBOUNCE_CYC_DEFAULT : button stable time in clk cycles (10 ms at 50 MHz)
// -----------------------------------------------------------------------------
package cpu_tick_pkg;

  typedef enum logic [1:0] {
    HALT = 2'b00,
    RUN  = 2'b01,
    STEP = 2'b10,
    FAST = 2'b11
  } tick_state_e;

  localparam int DEBOUNCE_CYC_DEFAULT = 500000;

endpackage : cpu_tick_pkg

// File: rtl/cpu_tick_ctrl_if.sv
// -----------------------------------------------------------------------------
// cpu_tick_ctrl_if
// Control/status bundle between the tick controller and the CPU/board glue.
//   mode      : requested mode (HALT/RUN/STEP/FAST), sampled every cycle
//   div       : run divisor, 0 behaves as 1
//   tick      : one-cycle CPU clock-enable pulse
//   heartbeat : toggles on every tick
//   tick_cnt  : ticks issued, wraps modulo 2^CNT_W
//   state     : current state for the LEDs
// Modports: master = tick controller, slave = consumer of the ticks.
// -----------------------------------------------------------------------------
interface cpu_tick_ctrl_if
  import cpu_tick_pkg::*;
#(
  parameter int DIV_W = 26,
  parameter int CNT_W = 16
);

  tick_state_e        mode;
  logic [DIV_W-1:0]   div;
  logic               tick;
  logic               heartbeat;
  logic [CNT_W-1:0]   tick_cnt;
  tick_state_e        state;

  modport master (
    input  mode, div,
    output tick, heartbeat, tick_cnt, state
  );

  modport slave (
    output mode, div,
    input  tick, heartbeat, tick_cnt, state
  );

endinterface : cpu_tick_ctrl_if

// File: rtl/cpu_tick_ctrl_btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Two-flop synchroniser, stable-time debounce counter and registered
// rising-edge pulse for a raw mechanical push button.
//   clk_i   : clock
//   reset_i : synchronous, active-high reset
//   btn_i   : raw asynchronous button, active-high
//   rise_o  : one-cycle pulse, one cycle after the debounced level rises
// The debounced level follows the synchronised input only after it has
// differed from the level for DEBOUNCE_CYC consecutive cycles.
// -----------------------------------------------------------------------------
module btn_debounce
  import cpu_tick_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEFAULT
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic btn_i,
  output logic rise_o
);

  localparam int            DB_W    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic            level_prev_q;
  logic            rise_q;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;

  // Counter restarts whenever the input agrees with the current level, so
  // only an uninterrupted disagreement of DEBOUNCE_CYC cycles flips it.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    level_d  = level_q;
    db_cnt_d = '0;
    if (sync2_q != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        level_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; this is what makes sync1 -> sync2 two real stages.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      rise_q       <= 1'b0;
      db_cnt_q     <= '0;
    end else begin
      sync1_q      <= btn_i;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      rise_q       <= level_q & ~level_prev_q;
      db_cnt_q     <= db_cnt_d;
    end
  end

  assign rise_o = rise_q;

endmodule : btn_debounce

// File: rtl/cpu_tick_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_tick_ctrl
// Clock-enable generator for the single-cycle MIPS core. The CPU runs on the
// 50 MHz board clock and advances only when tick is high.
//   clk_i      : board clock (MAX10_CLK1_50)
//   reset_i    : synchronous, active-high reset
//   step_btn_i : raw single-step push button, active-high
//   bus        : cpu_tick_ctrl_if.master (mode, div in; tick, heartbeat,
//                tick_cnt, state out)
// Modes: HALT no ticks; RUN one tick every max(div,1) cycles; FAST a tick
// every cycle; STEP one tick per debounced button press.
// Optional: define CPU_TICK_BURST_EN to make each STEP press issue a burst of
// BURST_LEN ticks spaced by the run divisor.
// -----------------------------------------------------------------------------
module cpu_tick_ctrl
  import cpu_tick_pkg::*;
#(
  parameter int DIV_W        = 26,
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEFAULT,
  parameter int CNT_W        = 16,
  parameter int BURST_LEN    = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             step_btn_i,
  cpu_tick_ctrl_if.master  bus
);

  if (BURST_LEN < 1) begin : g_bad_burst_len
    $error("cpu_tick_ctrl: BURST_LEN must be at least 1");
  end

  tick_state_e      state_q, state_d;
  logic [DIV_W-1:0] run_cnt_q, run_cnt_d;
  logic [DIV_W-1:0] div_m1;
  logic             tick_q, tick_d;
  logic             heartbeat_q, heartbeat_d;
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic             step_req;

`ifdef CPU_TICK_BURST_EN
  localparam int               BURST_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(BURST_LEN - 1);
  // Ticks still owed by the current burst; zero means no burst in progress.
  logic [BURST_W-1:0] burst_rem_q, burst_rem_d;
`endif

  btn_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_btn_debounce (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .btn_i   (step_btn_i),
    .rise_o  (step_req)
  );

  // Terminal count d-1 with div==0 folded onto d=1.
  assign div_m1 = (bus.div == '0) ? '0 : bus.div - 1'b1;

  // The state being entered (state_d) decides whether the registered tick
  // fires, so a mode change cancels any tick the old mode had pending.
  // The run counter only advances while both the current and next state
  // agree, which clears it on every entry and exit.
  always_comb begin
    state_d   = bus.mode;
    run_cnt_d = '0;
    tick_d    = 1'b0;
`ifdef CPU_TICK_BURST_EN
    burst_rem_d = '0;
`endif

    unique case (state_d)
      HALT: ;
      FAST: tick_d = 1'b1;
      RUN: begin
        if (state_q == RUN) begin
          // >= rather than == so a divisor shrunk below the count fires now.
          if (run_cnt_q >= div_m1) begin
            tick_d = 1'b1;
          end else begin
            run_cnt_d = run_cnt_q + 1'b1;
          end
        end
      end
      STEP: begin
`ifdef CPU_TICK_BURST_EN
        if (state_q == STEP) begin
          if (burst_rem_q != '0) begin
            burst_rem_d = burst_rem_q;
            if (run_cnt_q >= div_m1) begin
              tick_d      = 1'b1;
              burst_rem_d = burst_rem_q - 1'b1;
            end else begin
              run_cnt_d = run_cnt_q + 1'b1;
            end
          end else if (step_req) begin
            tick_d      = 1'b1;
            burst_rem_d = BURST_LAST;
          end
        end
`else
        if (state_q == STEP && step_req) begin
          tick_d = 1'b1;
        end
`endif
      end
      default: ;
    endcase

    tick_cnt_d  = tick_d ? tick_cnt_q + 1'b1 : tick_cnt_q;
    heartbeat_d = heartbeat_q ^ tick_d;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= HALT;
      run_cnt_q   <= '0;
      tick_q      <= 1'b0;
      heartbeat_q <= 1'b0;
      tick_cnt_q  <= '0;
`ifdef CPU_TICK_BURST_EN
      burst_rem_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      run_cnt_q   <= run_cnt_d;
      tick_q      <= tick_d;
      heartbeat_q <= heartbeat_d;
      tick_cnt_q  <= tick_cnt_d;
`ifdef CPU_TICK_BURST_EN
      burst_rem_q <= burst_rem_d;
`endif
    end
  end

  assign bus.tick      = tick_q;
  assign bus.heartbeat = heartbeat_q;
  assign bus.tick_cnt  = tick_cnt_q;
  assign bus.state     = state_q;

endmodule : cpu_tick_ctrl
